// File: rtl/tof_frame_bram_writer.sv
// rtl/tof_frame_bram_writer.sv - ping-pong frame writer from a sample stream into BRAM port A
// Tracks two banks with full flags; the reader releases a bank with a frame_done pulse.
module tof_frame_bram_writer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              drdy,
  output logic              rd_bank,
  input  logic              frame_done,
  output logic              frame_err
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             wr_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic [IDX_W-1:0] idx;
  logic             set_pend;
  logic             set_bank;
  logic             accept;
  logic             last_beat;
  logic             early_last;
  logic             release_bank;

  assign s_ready      = ~full[wr_bank];
  assign drdy         = full[rd_bank];
  assign accept       = s_valid & s_ready;
  assign last_beat    = accept & (idx == LAST_IDX);
  assign early_last   = accept & s_last & (idx != LAST_IDX);
  assign release_bank = frame_done & drdy;

  // The full flag lands one edge after the final accept, together with the final BRAM write.
  always_comb begin
    full_nxt = full;
    if (set_pend)
      full_nxt[set_bank] = 1'b1;
    if (release_bank)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      frame_err <= 1'b0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      idx       <= '0;
      set_pend  <= 1'b0;
      set_bank  <= 1'b0;
    end else begin
      wea       <= accept;
      frame_err <= early_last;
      set_pend  <= last_beat;
      full      <= full_nxt;
      if (accept) begin
        addra <= {wr_bank, idx};
        dina  <= s_data;
      end
      if (last_beat) begin
        idx      <= '0;
        wr_bank  <= ~wr_bank;
        set_bank <= wr_bank;
      end else if (early_last) begin
        idx <= '0;
      end else if (accept) begin
        idx <= idx + 1'b1;
      end
      if (release_bank)
        rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_tof_frame_bram_writer.sv
// tb/tb_tof_frame_bram_writer.sv - scoreboard bench for tof_frame_bram_writer
// Driver updates a frame-level model and queues expected writes; a monitor checks port A.
`timescale 1ns/1ps
module tb_tof_frame_bram_writer;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 9;
  localparam int FRAME_LEN = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              drdy;
  logic              rd_bank;
  logic              frame_done = 1'b0;
  logic              frame_err;

  tof_frame_bram_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .wea(wea), .addra(addra), .dina(dina), .drdy(drdy),
    .rd_bank(rd_bank), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  fr_bank[$];
  int  fr_vis[$];
  int  checks = 0;
  int  failures = 0;
  int  m_wr_bank = 0;
  int  m_rd_bank = 0;
  int  m_idx = 0;
  int  cyc = 0;

  function automatic bit m_drdy();
    return fr_vis.size() > 0 && fr_vis[0] <= cyc;
  endfunction

  function automatic bit m_ready();
    return fr_bank.size() < 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit fd,
                       output bit acc);
    wr_t e;
    @(negedge clk);
    cyc++;
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_ready()});
    chk("drdy", {31'd0, drdy}, {31'd0, m_drdy()});
    chk("rd_bank", {31'd0, rd_bank}, 32'(m_rd_bank));
    s_valid    = v;
    s_data     = d;
    s_last     = l;
    frame_done = fd;
    acc = v && m_ready();
    if (fd && m_drdy()) begin
      void'(fr_bank.pop_front());
      void'(fr_vis.pop_front());
      m_rd_bank ^= 1;
    end
    if (acc) begin
      e.addr = ADDR_W'(m_wr_bank * (1 << (ADDR_W - 1)) + m_idx);
      e.data = d;
      e.err  = l && (m_idx != FRAME_LEN - 1);
      exp_q.push_back(e);
      if (m_idx == FRAME_LEN - 1) begin
        fr_bank.push_back(m_wr_bank);
        fr_vis.push_back(cyc + 2);
        m_wr_bank ^= 1;
        m_idx = 0;
      end else if (l) begin
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic send_beats(input int n, input int base, input int last_at, input int fd_at,
                            input bit rnd);
    int sent = 0;
    int guard = 0;
    bit fd_sent = 1'b0;
    bit fd;
    bit acc;
    while (sent < n && guard < 2000) begin
      fd = (sent == fd_at) && !fd_sent;
      if (fd) fd_sent = 1'b1;
      cycle(1'b1, rnd ? DATA_W'($urandom) : DATA_W'(base + sent), sent == last_at, fd, acc);
      if (acc) sent++;
      guard++;
    end
    chk("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    frame_done = 1'b0;
    exp_q.delete();
    fr_bank.delete();
    fr_vis.delete();
    m_wr_bank = 0;
    m_rd_bank = 0;
    m_idx = 0;
    #1;
    chk("rst_wea", {31'd0, wea}, 32'd0);
    chk("rst_addra", 32'(addra), 32'd0);
    chk("rst_dina", 32'(dina), 32'd0);
    chk("rst_drdy", {31'd0, drdy}, 32'd0);
    chk("rst_rd_bank", {31'd0, rd_bank}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (wea) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(addra), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("addra", 32'(addra), 32'(mon_e.addr));
          chk("dina", 32'(dina), 32'(mon_e.data));
          chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.err});
        end
      end else begin
        chk("frame_err_idle", {31'd0, frame_err}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int guard;
    do_reset();

    // single frame, then a second frame without s_last
    send_beats(FRAME_LEN, 100, FRAME_LEN - 1, -1, 1'b0);
    idle(3);
    send_beats(FRAME_LEN, 300, -1, -1, 1'b0);

    // both banks full: third frame is offered and held off until frame_done
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'd500, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'd500, 1'b0, 1'b1, acc);
    send_beats(FRAME_LEN, 500, FRAME_LEN - 1, -1, 1'b0);

    // frame_done coincident with the final beat of the next frame
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    send_beats(FRAME_LEN, 700, FRAME_LEN - 1, FRAME_LEN - 1, 1'b0);
    idle(3);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    idle(2);

    // frame_done with nothing pending
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    idle(2);

    // early s_last on beat 10, then a full frame in the same bank
    send_beats(11, 900, 10, -1, 1'b0);
    idle(3);
    send_beats(FRAME_LEN, 1000, FRAME_LEN - 1, -1, 1'b0);
    idle(2);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) < 7, DATA_W'($urandom),
            (m_idx == FRAME_LEN - 1) ? 1'($urandom) : ($urandom_range(0, 59) == 0),
            $urandom_range(0, 9) == 0, acc);
    end
    guard = 0;
    while (fr_bank.size() > 0 && guard < 20) begin
      cycle(1'b0, '0, 1'b0, 1'b1, acc);
      guard++;
    end
    idle(2);

    // reset after beat 30 of a frame
    do_reset();
    send_beats(31, 2000, -1, -1, 1'b0);
    do_reset();
    send_beats(FRAME_LEN, 3000, FRAME_LEN - 1, -1, 1'b1);
    idle(3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tof_frame_bram_writer.md
# tof_frame_bram_writer

Writer end of the ToF sample buffer. Accepts a valid/ready stream of per-zone distance samples from the sensor interface and writes each frame into a two-bank (ping-pong) region of a dual-port BRAM through port A. Signals frame availability to the reader FSM via `drdy`, and frees a bank when the reader pulses `frame_done`. Applies backpressure when both banks hold unread frames.

## Interface
- `DATA_W`, 16: sample width; equals the BRAM word width.
- `ADDR_W`, 9: BRAM address width. The MSB selects the bank.
- `FRAME_LEN`, 64: samples per frame. Must satisfy 2 ≤ `FRAME_LEN` ≤ 2^(`ADDR_W`-1).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: input sample ready.
- `s_data` in `DATA_W`: distance sample.
- `s_last` in 1: sender's end-of-frame marker.
- `wea` out 1: BRAM port-A write enable (registered).
- `addra` out `ADDR_W`: BRAM port-A address (registered).
- `dina` out `DATA_W`: BRAM port-A data (registered).
- `drdy` out 1: at least one complete, unread frame is present.
- `rd_bank` out 1: bank the reader must read. Reader address = {`rd_bank`, index}.
- `frame_done` in 1: one-cycle pulse from the reader; releases bank `rd_bank`.
- `frame_err` out 1: one-cycle pulse; a frame was aborted by an early `s_last`.

## Operation
- State:
  - `wr_bank` (1 bit)
  - `rd_bank` (1 bit)
  - `full[1:0]`
  - beat counter `idx` (0..`FRAME_LEN`-1)
- `s_ready` = ~`full[wr_bank]`, combinational. A beat is accepted when `s_valid` and `s_ready` are both high.
- On an accepted beat, the next cycle drives:
  - `wea`=1
  - `addra` = {`wr_bank`, `idx`} zero-extended to `ADDR_W`, with `wr_bank` in the MSB
  - `dina` = `s_data`
  
  `idx` increments. At all other times `wea`=0; `addra` and `dina` hold their last values.
- Frame completes on the accepted beat with `idx` = `FRAME_LEN`-1, whether or not `s_last` is set. On completion:
  - `idx` returns to 0.
  - `wr_bank` toggles.
  - `full[old wr_bank]` is set one cycle later, on the same edge that the BRAM captures the final write.
- Early `s_last` (accepted beat with `idx` < `FRAME_LEN`-1):
  - The beat is still written.
  - `idx` returns to 0 and `wr_bank` is unchanged, so the partial frame is overwritten by the next frame.
  - `full` is unchanged.
  - `frame_err` pulses for one cycle, coincident with that beat's `wea`.
- `drdy` = `full[rd_bank]`, registered-equivalent (it derives only from flops).
- `frame_done` with `drdy`=1: clears `full[rd_bank]` and toggles `rd_bank`. `frame_done` with `drdy`=0 is ignored.
- Frames are delivered in write order. `rd_bank` always points to the oldest full bank.
- When completion and `frame_done` occur in the same cycle, both take effect. Set and clear act on different banks, except when `rd_bank`==`wr_bank`; that case cannot occur while the bank being written is full.
- When both banks are full, `s_ready` stays 0 until a `frame_done` arrives. The freed bank is then the next `wr_bank`, and `s_ready` rises in the cycle after `frame_done`.

## Timing
- Reset values (asynchronous on `rst`=0):
  - `wea`=0, `addra`=0, `dina`=0
  - `drdy`=0, `rd_bank`=0, `frame_err`=0
  - `wr_bank`=0, `full`=00, `idx`=0
  - `s_ready`=1 once out of reset
- Write latency: a beat accepted at edge E appears on the port-A outputs during E..E+1 and is captured by the BRAM at E+1.
- Frame latency: final beat accepted at edge E gives `drdy`=1 from E+1. The reader may issue its first read in the cycle after E+1.
- Throughput: one beat per cycle with no bubbles across frame boundaries while a free bank exists.
- Reset mid-frame:
  - The partial frame is discarded and all frames are lost.
  - No `wea` pulse occurs during or right after reset.
  - The first post-reset beat writes address 0.

## Test plan
- Single frame of 64 beats, `s_data` = 100+i, with `s_last` on beat 63:
  - Writes addresses 0..63 with values 100..163.
  - `drdy` rises 1 cycle after the last accept.
  - `rd_bank`=0, `frame_err`=0.
- Two back-to-back frames with no `frame_done`, then a third frame offered:
  - Frame 2 is written to addresses 256..319.
  - `s_ready`=0 after the 128th accept and stays 0.
  - `frame_done` pulse: `rd_bank` becomes 1, `drdy` stays 1, and `s_ready` returns to 1 the next cycle.
- `s_last` on beat 10:
  - `frame_err` pulses once and `drdy` stays 0.
  - The next frame starts again at address 0 in the same bank.
- 64 beats without `s_last`: frame completes normally, `drdy`=1, no `frame_err`.
- `frame_done` applied in the same cycle as the final beat of frame 2, with frame 1 pending:
  - `rd_bank` becomes 1 and `full` = 10.
  - `drdy` stays 1 and `s_ready`=1.
- `rst` asserted after beat 30:
  - All outputs return to their reset values immediately.
  - The next frame writes from address 0 and `drdy` stays 0 until that frame completes.
- `frame_done` pulse while `drdy`=0: no state change.
